// File: rtl/saniye_zamanlayici.sv
// Seconds tick, seconds-in-cycle counter and debounced pedestrian request front-end
// for the traffic-light controller.
module saniye_zamanlayici #(
  parameter int unsigned CLK_HZ     = 24_000_000,
  parameter int unsigned DONGU_SURE = 60,
  parameter int unsigned DEB_CYCLES = 480_000
) (
  input  logic       sayac,
  input  logic       reset,
  input  logic       calis,
  input  logic       yaya_buton,
  input  logic       yaya_onay,
  output logic       tick_1hz,
  output logic [5:0] saniye,
  output logic       dongu_basi,
  output logic       yaya_istek
);

  localparam int unsigned PW = $clog2(CLK_HZ);
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [PW-1:0] PRE_SON = PW'(CLK_HZ - 1);
  localparam logic [5:0]    SAN_SON = 6'(DONGU_SURE - 1);
  localparam logic [DW-1:0] DEB_SON = DW'(DEB_CYCLES - 1);

  logic [PW-1:0] pre;
  logic          senk1;
  logic          senk2;
  logic          deb_seviye;
  logic          deb_seviye_d;
  logic [DW-1:0] deb_say;
  logic          istek_kur_c;

  // Prescaler: one tick every CLK_HZ running cycles, holds while paused
  always_ff @(posedge sayac) begin
    if (reset) begin
      pre      <= '0;
      tick_1hz <= 1'b0;
    end else if (calis) begin
      if (pre == PRE_SON) begin
        pre      <= '0;
        tick_1hz <= 1'b1;
      end else begin
        pre      <= pre + PW'(1);
        tick_1hz <= 1'b0;
      end
    end else begin
      tick_1hz <= 1'b0;
    end
  end

  // Seconds-in-cycle counter, updated on the tick edge so value and tick align
  always_ff @(posedge sayac) begin
    if (reset) begin
      saniye     <= '0;
      dongu_basi <= 1'b0;
    end else if (calis && pre == PRE_SON) begin
      if (saniye == SAN_SON) begin
        saniye     <= '0;
        dongu_basi <= 1'b1;
      end else begin
        saniye     <= saniye + 6'd1;
        dongu_basi <= 1'b0;
      end
    end else begin
      dongu_basi <= 1'b0;
    end
  end

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge sayac) begin
    if (reset) begin
      senk1 <= 1'b0;
      senk2 <= 1'b0;
    end else begin
      senk1 <= yaya_buton;
      senk2 <= senk1;
    end
  end

  // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge sayac) begin
    if (reset) begin
      deb_seviye   <= 1'b0;
      deb_seviye_d <= 1'b0;
      deb_say      <= '0;
    end else begin
      deb_seviye_d <= deb_seviye;
      if (senk2 == deb_seviye) begin
        deb_say <= '0;
      end else if (deb_say == DEB_SON) begin
        deb_seviye <= senk2;
        deb_say    <= '0;
      end else begin
        deb_say <= deb_say + DW'(1);
      end
    end
  end

  assign istek_kur_c = deb_seviye & ~deb_seviye_d;

  // Pending request: set on debounced press, cleared by acknowledge; set has priority
  always_ff @(posedge sayac) begin
    if (reset) begin
      yaya_istek <= 1'b0;
    end else if (istek_kur_c) begin
      yaya_istek <= 1'b1;
    end else if (yaya_onay) begin
      yaya_istek <= 1'b0;
    end
  end

endmodule

// File: tb/tb_saniye_zamanlayici.sv
// Directed bench for saniye_zamanlayici with CLK_HZ=10, DONGU_SURE=5, DEB_CYCLES=4.
module tb_saniye_zamanlayici;

  logic       sayac = 1'b0;
  logic       reset = 1'b0;
  logic       calis = 1'b0;
  logic       yaya_buton = 1'b0;
  logic       yaya_onay = 1'b0;
  logic       tick_1hz;
  logic [5:0] saniye;
  logic       dongu_basi;
  logic       yaya_istek;

  int n_cmp = 0;
  int n_err = 0;

  saniye_zamanlayici #(
    .CLK_HZ    (10),
    .DONGU_SURE(5),
    .DEB_CYCLES(4)
  ) dut (
    .sayac     (sayac),
    .reset     (reset),
    .calis     (calis),
    .yaya_buton(yaya_buton),
    .yaya_onay (yaya_onay),
    .tick_1hz  (tick_1hz),
    .saniye    (saniye),
    .dongu_basi(dongu_basi),
    .yaya_istek(yaya_istek)
  );

  always #5 sayac = ~sayac;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are stable and inputs may change 1 ns later
  task automatic step();
    @(posedge sayac);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_btn(input int hi, input int lo);
    yaya_buton = 1'b1;
    for (int i = 0; i < hi; i++) begin step(); chk("glitch_istek", 32'(yaya_istek), 0); end
    yaya_buton = 1'b0;
    for (int i = 0; i < lo; i++) begin step(); chk("glitch_istek", 32'(yaya_istek), 0); end
  endtask

  initial begin
    #2;
    // 1: reset state and free-running ticks
    calis = 1'b1;
    do_reset();
    chk("rst_tick", 32'(tick_1hz), 0);
    chk("rst_saniye", 32'(saniye), 0);
    chk("rst_dongu", 32'(dongu_basi), 0);
    chk("rst_istek", 32'(yaya_istek), 0);
    for (int n = 1; n <= 60; n++) begin
      step();
      chk("t1_tick", 32'(tick_1hz), (n % 10 == 0) ? 1 : 0);
      chk("t1_saniye", 32'(saniye), 32'((n / 10) % 5));
      chk("t1_dongu", 32'(dongu_basi), (n == 50) ? 1 : 0);
    end

    // 2: pause keeps the partial second
    do_reset();
    for (int n = 1; n <= 15; n++) step();
    chk("t2_saniye_pre", 32'(saniye), 1);
    calis = 1'b0;
    for (int n = 0; n < 7; n++) begin
      step();
      chk("t2_pause_tick", 32'(tick_1hz), 0);
      chk("t2_pause_saniye", 32'(saniye), 1);
    end
    calis = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      chk("t2_resume_tick", 32'(tick_1hz), (n == 5) ? 1 : 0);
    end
    chk("t2_saniye_post", 32'(saniye), 2);

    // 3: clean press, latency 7, held once, acknowledged
    calis = 1'b0;
    do_reset();
    yaya_buton = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      chk("t3_istek", 32'(yaya_istek), (n >= 7) ? 1 : 0);
    end
    yaya_buton = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      chk("t3_release_istek", 32'(yaya_istek), 1);
    end
    yaya_onay = 1'b1;
    step();
    yaya_onay = 1'b0;
    chk("t3_ack_clear", 32'(yaya_istek), 0);
    for (int n = 0; n < 10; n++) begin
      step();
      chk("t3_no_second", 32'(yaya_istek), 0);
    end

    // 4: glitches rejected, then a clean press accepted
    do_reset();
    pulse_btn(1, 5);
    pulse_btn(2, 5);
    pulse_btn(3, 5);
    yaya_buton = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      chk("t4_istek", 32'(yaya_istek), (n >= 7) ? 1 : 0);
    end
    yaya_buton = 1'b0;

    // 5: ack coinciding with set loses; ack while idle ignored
    do_reset();
    yaya_buton = 1'b1;
    for (int n = 1; n <= 6; n++) step();
    chk("t5_before_set", 32'(yaya_istek), 0);
    yaya_onay = 1'b1;
    step();
    chk("t5_set_wins", 32'(yaya_istek), 1);
    step();
    chk("t5_ack_clears", 32'(yaya_istek), 0);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t5_idle_ack", 32'(yaya_istek), 0);
    end
    yaya_onay = 1'b0;
    yaya_buton = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      chk("t5_release", 32'(yaya_istek), 0);
    end

    // 6: reset mid-second with a pending request
    calis = 1'b1;
    do_reset();
    yaya_buton = 1'b1;
    for (int n = 1; n <= 35; n++) begin
      step();
      if (n == 20) yaya_buton = 1'b0;
    end
    chk("t6_pre_saniye", 32'(saniye), 3);
    chk("t6_pre_istek", 32'(yaya_istek), 1);
    do_reset();
    chk("t6_rst_tick", 32'(tick_1hz), 0);
    chk("t6_rst_saniye", 32'(saniye), 0);
    chk("t6_rst_dongu", 32'(dongu_basi), 0);
    chk("t6_rst_istek", 32'(yaya_istek), 0);
    for (int n = 1; n <= 10; n++) begin
      step();
      chk("t6_tick", 32'(tick_1hz), (n == 10) ? 1 : 0);
      chk("t6_istek", 32'(yaya_istek), 0);
    end
    chk("t6_saniye", 32'(saniye), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/saniye_zamanlayici.md
Name: saniye_zamanlayici

Overview:
Timing and request front-end that sits directly upstream of the traffic-light controller. It divides the system clock into a one-second tick and maintains the seconds-in-cycle count that the controller uses to select its phase. It also synchronises and debounces the pedestrian push-button and holds a pending-request flag until the controller acknowledges it.

Parameters:
CLK_HZ, 24_000_000, clock cycles per second; the tick period is exactly CLK_HZ cycles; legal range >= 2.
DONGU_SURE, 60, seconds per full light cycle; saniye counts 0..DONGU_SURE-1; legal range 2..64.
DEB_CYCLES, 480_000, consecutive stable synchronised cycles required to accept a button level change (20 ms at 24 MHz); legal range >= 1.

Ports:
sayac  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
calis  in  1  run enable; 0 freezes prescaler and saniye.
yaya_buton  in  1  raw asynchronous pedestrian button, 1 = pressed.
yaya_onay  in  1  request acknowledge from controller; single-cycle or level.
tick_1hz  out  1  one-cycle pulse per elapsed second.
saniye  out  6  seconds within current cycle, 0..DONGU_SURE-1.
dongu_basi  out  1  one-cycle pulse when saniye wraps to 0.
yaya_istek  out  1  pending pedestrian request, held until acknowledged.

Behaviour:
- Reset (sampled at a rising edge while reset=1): prescaler=0, saniye=0, tick_1hz=0, dongu_basi=0, yaya_istek=0, both synchroniser flops=0, debounced level=0, debounce counter=0. Reset overrides every other input, including mid-second and while a request is pending.
- Prescaler: width ceil(log2(CLK_HZ)). When calis=1 it increments each cycle. At CLK_HZ-1 it wraps to 0 and the same edge registers tick_1hz=1 for exactly one cycle. When calis=0 the prescaler holds and tick_1hz=0.
- First tick after reset release (calis=1 throughout): tick_1hz is high during the CLK_HZ-th cycle after release. Subsequent ticks are spaced exactly CLK_HZ cycles apart.
- Seconds counter: saniye updates on the same edge that raises tick_1hz, so the new value is visible alongside the tick. At DONGU_SURE-1 it wraps to 0 and dongu_basi=1 in that same cycle; otherwise dongu_basi=0. saniye never exceeds DONGU_SURE-1.
- Pause: calis=0 freezes both prescaler and saniye without clearing them. Resuming continues from the stored prescaler value, so a partial second is not lost.
- Button path:
  - 2-flop synchroniser feeds the debounce logic.
  - If the synchronised value equals the debounced level, the counter is cleared.
  - If it differs, the counter increments; when it reaches DEB_CYCLES-1 and the value still differs, the debounced level takes the new value and the counter clears.
  - Any return to the debounced level before that point clears the counter (bounce rejected).
  - The button path runs regardless of calis.
- Request flag:
  - A 0->1 transition of the debounced level sets yaya_istek on the next edge.
  - yaya_onay=1 while yaya_istek=1 clears it on that edge.
  - If a set and yaya_onay occur in the same cycle, the set wins and yaya_istek stays 1.
  - yaya_onay while yaya_istek=0 is ignored.
  - A held button generates exactly one request; releasing the button generates none.
- Latency from raw press to yaya_istek=1 with a clean input: 2 (synchroniser) + DEB_CYCLES + 1 cycles.
- All outputs are registered.

Test Plan:
(Bench uses CLK_HZ=10, DONGU_SURE=5, DEB_CYCLES=4.)
1. Reset, then calis=1 for 60 cycles -> tick_1hz high on cycles 10,20,...,60. saniye follows 1,2,3,4,0,1. dongu_basi is high only on cycle 50.
2. calis=1 for 15 cycles, calis=0 for 7 cycles, then calis=1 -> no tick during the pause; the next tick arrives 5 cycles after resume; saniye goes 1 -> 2.
3. Clean press held for 20 cycles -> yaya_istek rises exactly 7 cycles after the press, stays 1 after release; a 1-cycle yaya_onay clears it on the next edge; no second request appears.
4. Button glitches of 1-3 cycles separated by low periods, then a clean press -> glitches produce no request; only the clean press sets yaya_istek.
5. Drive yaya_onay=1 on the exact cycle yaya_istek would be set -> yaya_istek=1 afterwards. Drive yaya_onay while idle -> no effect.
6. Assert reset for 1 cycle mid-second with saniye=3 and yaya_istek=1 -> all outputs read 0 the following cycle; the first new tick arrives 10 cycles after reset release.
